// File: rtl/jesd204b_tx_link_ctrl.sv
// JESD204B TX link bring-up/supervision controller: SYSREF generation, scrambler latch,
// bring-up retry on timeout and run-time resync counting.
module jesd204b_tx_link_ctrl #(
   parameter int unsigned SYSREF_PERIOD  = 64,
   parameter int unsigned SYSREF_WIDTH   = 2,
   parameter int unsigned SYNC_TIMEOUT   = 4096,
   parameter int unsigned MAX_RETRY      = 3,
   parameter logic [7:0]  USER_DATA_CODE = 8'd10
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic       enable,
   input  logic       sysref_mode,
   input  logic       scrambler_req,
   input  logic       sync_b,
   input  logic [7:0] link_state,
   output logic       sysref_out,
   output logic       scrambler_is_on,
   output logic       link_up,
   output logic       link_fail,
   output logic [7:0] resync_cnt,
   output logic [2:0] ctrl_state
);

   localparam logic [15:0] PeriodLast  = 16'(SYSREF_PERIOD - 1);
   localparam logic [15:0] WidthLim    = 16'(SYSREF_WIDTH);
   localparam logic [15:0] WidthLast   = 16'(SYSREF_WIDTH - 1);
   localparam logic [15:0] TimeoutLast = 16'(SYNC_TIMEOUT - 1);
   localparam logic [15:0] RetryLast   = 16'd15;
   localparam logic [3:0]  MaxRetry    = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      StOff   = 3'd0,
      StPulse = 3'd1,
      StWait  = 3'd2,
      StRetry = 3'd3,
      StUp    = 3'd4,
      StFail  = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [15:0] phase_q, phase_d;
   logic [3:0]  attempt_q, attempt_d;
   logic [7:0]  resync_q, resync_d;
   logic        scr_q, scr_d;
   logic        sysref_q, sysref_d;
   logic        link_up_q, link_fail_q;
   logic        sync_meta_q, sync_s_q;
   logic        entering_pulse;

   // SYNC~ idles high, so the synchroniser resets to the deasserted level.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sync_meta_q <= 1'b1;
         sync_s_q    <= 1'b1;
      end else begin
         sync_meta_q <= sync_b;
         sync_s_q    <= sync_meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = StOff;
      end else begin
         case (state_q)
            StOff:   state_d = StPulse;
            StPulse: if (phase_q == WidthLast) state_d = StWait;
            StWait: begin
               // A match in the timeout cycle still wins over retry/fail.
               if (link_state == USER_DATA_CODE) begin
                  state_d = StUp;
               end else if (timer_q == TimeoutLast) begin
                  state_d = (attempt_q < MaxRetry) ? StRetry : StFail;
               end
            end
            StRetry: if (timer_q == RetryLast) state_d = StPulse;
            StUp:    if (!sync_s_q) state_d = StWait;
            StFail:  state_d = StFail;
            default: state_d = StOff;
         endcase
      end
   end

   always_comb begin
      entering_pulse = (state_d == StPulse) && (state_q != StPulse);

      timer_d = 16'd0;
      if ((state_d == state_q) && ((state_q == StWait) || (state_q == StRetry))) begin
         timer_d = timer_q + 16'd1;
      end

      // Phase restarts at every pulse so periodic SYSREF is aligned to the bring-up pulse.
      if ((state_d == StOff) || entering_pulse) begin
         phase_d = 16'd0;
      end else if (phase_q == PeriodLast) begin
         phase_d = 16'd0;
      end else begin
         phase_d = phase_q + 16'd1;
      end

      attempt_d = attempt_q;
      if ((state_d == StOff) || (state_d == StUp)) begin
         attempt_d = 4'd0;
      end else if (entering_pulse) begin
         attempt_d = attempt_q + 4'd1;
      end

      resync_d = resync_q;
      if ((state_q == StUp) && (state_d == StWait) && (resync_q != 8'hff)) begin
         resync_d = resync_q + 8'd1;
      end

      scr_d = entering_pulse ? scrambler_req : scr_q;

      sysref_d = (state_d == StPulse) ||
                 (sysref_mode && ((state_d == StWait) || (state_d == StUp)) &&
                  (phase_d < WidthLim));
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q     <= StOff;
         timer_q     <= 16'd0;
         phase_q     <= 16'd0;
         attempt_q   <= 4'd0;
         resync_q    <= 8'd0;
         scr_q       <= 1'b0;
         sysref_q    <= 1'b0;
         link_up_q   <= 1'b0;
         link_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         phase_q     <= phase_d;
         attempt_q   <= attempt_d;
         resync_q    <= resync_d;
         scr_q       <= scr_d;
         sysref_q    <= sysref_d;
         link_up_q   <= (state_d == StUp);
         link_fail_q <= (state_d == StFail);
      end
   end

   assign sysref_out      = sysref_q;
   assign scrambler_is_on = scr_q;
   assign link_up         = link_up_q;
   assign link_fail       = link_fail_q;
   assign resync_cnt      = resync_q;
   assign ctrl_state      = state_q;

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// Bench for jesd204b_tx_link_ctrl: directed bring-up, retry/fail, periodic SYSREF and resync
// scenarios checked every cycle against a state/dwell-time model plus literal expectations.
module tb_jesd204b_tx_link_ctrl;

   localparam int P  = 64;
   localparam int W  = 2;
   localparam int TO = 64;
   localparam int MR = 3;

   logic       clk = 1'b0;
   logic       reset_b = 1'b0;
   logic       enable = 1'b0;
   logic       sysref_mode = 1'b0;
   logic       scrambler_req = 1'b0;
   logic       sync_b = 1'b1;
   logic [7:0] link_state = 8'd0;
   logic       sysref_out, scrambler_is_on, link_up, link_fail;
   logic [7:0] resync_cnt;
   logic [2:0] ctrl_state;

   int checks = 0;
   int failures = 0;

   jesd204b_tx_link_ctrl #(
      .SYSREF_PERIOD (P),
      .SYSREF_WIDTH  (W),
      .SYNC_TIMEOUT  (TO),
      .MAX_RETRY     (MR),
      .USER_DATA_CODE(8'd10)
   ) dut (
      .clk            (clk),
      .reset_b        (reset_b),
      .enable         (enable),
      .sysref_mode    (sysref_mode),
      .scrambler_req  (scrambler_req),
      .sync_b         (sync_b),
      .link_state     (link_state),
      .sysref_out     (sysref_out),
      .scrambler_is_on(scrambler_is_on),
      .link_up        (link_up),
      .link_fail      (link_fail),
      .resync_cnt     (resync_cnt),
      .ctrl_state     (ctrl_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: state code, cycles spent in it, cycles since last pulse start.
   int m_st = 0, m_dwell = 0, m_since = 0, m_att = 0, m_resync = 0;
   bit m_s1 = 1'b1, m_s2 = 1'b1, m_scr = 1'b0;
   bit e_sysref = 1'b0, e_up = 1'b0, e_fail = 1'b0;

   initial forever begin
      @(posedge clk or negedge reset_b);
      if (!reset_b) begin
         m_st = 0; m_dwell = 0; m_since = 0; m_att = 0; m_resync = 0;
         m_s1 = 1'b1; m_s2 = 1'b1; m_scr = 1'b0;
         e_sysref = 1'b0; e_up = 1'b0; e_fail = 1'b0;
      end else begin
         int  nxt;
         bit  seen;
         seen = m_s2;
         m_s2 = m_s1;
         m_s1 = sync_b;
         nxt = m_st;
         if (!enable) nxt = 0;
         else if (m_st == 0) nxt = 1;
         else if (m_st == 1 && m_dwell == W - 1) nxt = 2;
         else if (m_st == 2 && link_state == 8'd10) nxt = 4;
         else if (m_st == 2 && m_dwell == TO - 1) nxt = (m_att < MR) ? 3 : 5;
         else if (m_st == 3 && m_dwell == 15) nxt = 1;
         else if (m_st == 4 && !seen) begin
            nxt = 2;
            if (m_resync < 255) m_resync++;
         end
         if (nxt == 1 && m_st != 1) begin
            m_att++;
            m_since = 0;
            m_scr = scrambler_req;
         end else begin
            m_since++;
         end
         if (nxt == 0 || nxt == 4) m_att = 0;
         m_dwell = (nxt != m_st) ? 0 : m_dwell + 1;
         m_st = nxt;
         e_sysref = (nxt == 1) || (sysref_mode && (nxt == 2 || nxt == 4) && (m_since % P) < W);
         e_up = (nxt == 4);
         e_fail = (nxt == 5);
      end
   end

   initial forever begin
      @(negedge clk);
      if (reset_b) begin
         chk("ctrl_state", int'(ctrl_state), m_st);
         chk("sysref_out", int'(sysref_out), int'(e_sysref));
         chk("link_up", int'(link_up), int'(e_up));
         chk("link_fail", int'(link_fail), int'(e_fail));
         chk("scrambler_is_on", int'(scrambler_is_on), int'(m_scr));
         chk("resync_cnt", int'(resync_cnt), m_resync);
      end
   end

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int cnt, rises, last_rise, prev;
      repeat (3) @(negedge clk);
      chk("reset sysref_out", int'(sysref_out), 0);
      chk("reset scrambler_is_on", int'(scrambler_is_on), 0);
      chk("reset link_up/fail", int'({link_up, link_fail}), 0);
      chk("reset resync_cnt", int'(resync_cnt), 0);
      chk("reset ctrl_state", int'(ctrl_state), 0);
      reset_b = 1'b1;
      ticks(2);

      // One-shot bring-up with scrambler requested on.
      scrambler_req = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      chk("enable->PULSE state", int'(ctrl_state), 1);
      cnt = int'(sysref_out);
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         cnt += int'(sysref_out);
      end
      chk("one-shot pulse width", cnt, 2);
      link_state = 8'd10;
      @(negedge clk);
      chk("bring-up link_up", int'(link_up), 1);
      chk("bring-up ctrl_state", int'(ctrl_state), 4);
      chk("bring-up scrambler", int'(scrambler_is_on), 1);

      scrambler_req = 1'b0;
      ticks(10);
      chk("scrambler held while UP", int'(scrambler_is_on), 1);

      // SYNC~ drops while UP; link layer leaves USER_DATA until SYNC~ returns.
      for (int d = 0; d < 300; d++) begin
         sync_b = 1'b0;
         link_state = 8'd0;
         cnt = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt++;
            if (!link_up) break;
         end
         if (d == 0) begin
            chk("sync drop latency", cnt, 3);
            chk("first resync_cnt", int'(resync_cnt), 1);
         end
         ticks(2);
         sync_b = 1'b1;
         ticks(3);
         link_state = 8'd10;
         cnt = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (link_up) break;
            cnt++;
         end
         if (cnt >= 20) chk("re-UP timeout", cnt, 0);
      end
      chk("resync saturated", int'(resync_cnt), 255);

      // enable low and USER_DATA in the same WAIT_DATA cycle: OFF wins.
      sync_b = 1'b0;
      link_state = 8'd0;
      ticks(4);
      chk("in WAIT_DATA", int'(ctrl_state), 2);
      enable = 1'b0;
      link_state = 8'd10;
      sync_b = 1'b1;
      @(negedge clk);
      chk("disable beats UP state", int'(ctrl_state), 0);
      ticks(3);
      chk("disable beats UP link_up", int'(link_up), 0);
      chk("resync kept through OFF", int'(resync_cnt), 255);

      // Never reaching USER_DATA: three attempts, then FAIL.
      link_state = 8'd0;
      enable = 1'b1;
      cnt = 0;
      rises = 0;
      prev = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         cnt++;
         if (sysref_out && !prev) rises++;
         prev = int'(sysref_out);
         if (link_fail) break;
      end
      chk("cycles to FAIL", cnt, 231);
      chk("attempt pulses", rises, 3);
      chk("FAIL ctrl_state", int'(ctrl_state), 5);
      ticks(5);
      chk("FAIL sticky", int'(link_fail), 1);
      enable = 1'b0;
      @(negedge clk);
      chk("FAIL->OFF", int'(ctrl_state), 0);

      // Periodic SYSREF: silent in OFF, 64-cycle spacing through WAIT_DATA and UP.
      sysref_mode = 1'b1;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cnt += int'(sysref_out);
      end
      chk("no periodic pulses in OFF", cnt, 0);
      enable = 1'b1;
      rises = 0;
      last_rise = -1;
      prev = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 20) link_state = 8'd10;
         if (sysref_out && !prev) begin
            if (last_rise >= 0) chk("periodic spacing", i - last_rise, 64);
            last_rise = i;
            rises++;
         end
         prev = int'(sysref_out);
      end
      chk("periodic rise count", rises, 5);
      chk("periodic UP", int'(link_up), 1);

      // Reset in the middle of a pulse drops SYSREF immediately.
      enable = 1'b0;
      sysref_mode = 1'b0;
      ticks(2);
      enable = 1'b1;
      @(negedge clk);
      chk("pulse before reset", int'(sysref_out), 1);
      #2 reset_b = 1'b0;
      #1;
      chk("async reset sysref", int'(sysref_out), 0);
      chk("async reset resync", int'(resync_cnt), 0);
      ticks(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
